// File: rtl/scope_trigger_capture.sv
// Triggered capture buffer for a sampled ADC stream: pre-trigger history, level or forced
// trigger, post-trigger fill, then sequential readout starting at the oldest sample.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for arm
// PRETRIG | collecting the pre-trigger history, trigger ignored
// ARMED   | writing the ring buffer, looking for a level crossing/force
// POST    | filling the remaining post-trigger samples
// DONE    | capture complete, samples readable via rd_en
module scope_trigger_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_edge,
    input  logic [ADDR_W-1:0] pretrig,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRETRIG,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_addr, trig_addr, pre_r, rd_cnt;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] prev, lvl_r;
    logic              prev_valid, force_pend, edge_r;

    logic              arm_ok, capturing, wr_en, level_hit, trig_hit;
    logic              pre_done, post_done, rd_fire, rd_last, enter_done;
    logic [ADDR_W:0]   cnt_inc, post_len;
    logic [ADDR_W-1:0] trig_addr_nxt;

    always_comb begin
        arm_ok    = arm && (state == S_IDLE || state == S_DONE);
        capturing = (state == S_PRETRIG) || (state == S_ARMED) || (state == S_POST);
        wr_en     = capturing && sample_valid;
        cnt_inc   = cnt + 1'b1;
        post_len  = (ADDR_W+1)'(DEPTH) - {1'b0, pre_r};
        if (edge_r)
            level_hit = prev_valid && (prev > lvl_r) && (sample_in <= lvl_r);
        else
            level_hit = prev_valid && (prev < lvl_r) && (sample_in >= lvl_r);
        trig_hit      = (state == S_ARMED) && sample_valid && (force_pend || level_hit);
        pre_done      = (state == S_PRETRIG) && sample_valid && (cnt_inc == {1'b0, pre_r});
        post_done     = (state == S_POST) && sample_valid && (cnt_inc == post_len);
        rd_fire       = (state == S_DONE) && rd_en && !arm;
        rd_last       = rd_fire && (rd_cnt == '1);
        trig_addr_nxt = trig_hit ? wr_ptr : trig_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (arm) state_nxt = (pretrig == '0) ? S_ARMED : S_PRETRIG;
            S_PRETRIG: if (pre_done) state_nxt = S_ARMED;
            S_ARMED:   if (trig_hit) state_nxt = (post_len == 1) ? S_DONE : S_POST;
            S_POST:    if (post_done) state_nxt = S_DONE;
            S_DONE: begin
                if (arm)          state_nxt = (pretrig == '0) ? S_ARMED : S_PRETRIG;
                else if (rd_last) state_nxt = S_IDLE;
            end
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = capturing;
        done = (state == S_DONE);
    end

    assign enter_done = (state != S_DONE) && (state_nxt == S_DONE);

    // Buffer contents survive reset; only the write enable is gated.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) mem[wr_ptr] <= sample_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_addr    <= '0;
            trig_addr  <= '0;
            pre_r      <= '0;
            rd_cnt     <= '0;
            cnt        <= '0;
            prev       <= '0;
            lvl_r      <= '0;
            prev_valid <= 1'b0;
            force_pend <= 1'b0;
            edge_r     <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) rd_data <= mem[rd_addr];
            if (arm_ok) begin
                lvl_r      <= trig_level;
                edge_r     <= trig_edge;
                pre_r      <= pretrig;
                wr_ptr     <= '0;
                cnt        <= '0;
                rd_cnt     <= '0;
                prev_valid <= 1'b0;
                force_pend <= 1'b0;
            end else begin
                if (wr_en) begin
                    wr_ptr     <= wr_ptr + 1'b1;
                    prev       <= sample_in;
                    prev_valid <= 1'b1;
                end
                if (pre_done || post_done) cnt <= '0;
                else if ((state == S_PRETRIG || state == S_POST) && sample_valid) cnt <= cnt_inc;
                // The trigger sample is the first post-trigger sample.
                if (trig_hit) begin
                    trig_addr  <= wr_ptr;
                    cnt        <= 1;
                    force_pend <= 1'b0;
                end else if (state == S_ARMED && force_trig) begin
                    force_pend <= 1'b1;
                end
                if (enter_done) rd_addr <= trig_addr_nxt - pre_r;
                else if (rd_fire) rd_addr <= rd_addr + 1'b1;
                if (rd_fire) rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Bench for scope_trigger_capture: directed vector table, randomized captures checked
// against a stream-level model, and hand-written reset/arm/readout corner sequences.
module tb_scope_trigger_capture;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] sample_in;
    logic              sample_valid;
    logic [DATA_W-1:0] trig_level;
    logic              trig_edge;
    logic [ADDR_W-1:0] pretrig;
    logic              arm, force_trig, rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid, busy, done;

    always #5 clk = ~clk;

    scope_trigger_capture #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
        .trig_level(trig_level), .trig_edge(trig_edge), .pretrig(pretrig), .arm(arm),
        .force_trig(force_trig), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .done(done)
    );

    typedef struct {
        logic [7:0] lvl;
        logic       edge_f;
        logic [3:0] pre;
        logic [7:0] start;
        logic [7:0] step;
        int         force_after;
        bit         stall;
        bit         arm_in_post;
        bit         has_exp;
        logic [7:0] exp0, exp1, exp2;
    } vec_t;

    vec_t       vecs [6];
    logic [7:0] stream [$];
    logic [7:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Trigger index within the sample stream, from the capture rules alone.
    function automatic int find_trig(input vec_t v);
        for (int i = int'(v.pre); i < stream.size(); i++) begin
            if (v.force_after >= int'(v.pre) && i >= v.force_after) return i;
            if (i >= 1) begin
                if (!v.edge_f && stream[i-1] < v.lvl && stream[i] >= v.lvl) return i;
                if (v.edge_f && stream[i-1] > v.lvl && stream[i] <= v.lvl) return i;
            end
        end
        return -1;
    endfunction

    task automatic build_ramp(input vec_t v);
        logic [7:0] x;
        x = v.start;
        stream.delete();
        for (int i = 0; i < 300; i++) begin
            stream.push_back(x);
            x = x + v.step;
        end
    endtask

    task automatic do_arm(input vec_t v);
        trig_level = v.lvl;
        trig_edge  = v.edge_f;
        pretrig    = v.pre;
        arm        = 1'b1;
        @(negedge clk);
        arm        = 1'b0;
    endtask

    // Feeds the stream until done; returns with exp_q holding the expected readout.
    task automatic run_capture(input string tag, input vec_t v);
        int  trig, last, j, cyc;
        bit  got_done, forced;
        trig = find_trig(v);
        exp_q.delete();
        if (trig < 0) begin
            chk({tag, "_model_trigger"}, 0, 1);
            return;
        end
        last = trig + DEPTH - int'(v.pre) - 1;
        for (int k = trig - int'(v.pre); k <= last; k++) exp_q.push_back(stream[k]);
        do_arm(v);
        chk({tag, "_busy_after_arm"}, busy, 1);
        j = 0; cyc = 0; got_done = 0; forced = 0;
        while (!got_done && cyc < 2000 && j < stream.size()) begin
            if (v.force_after >= 0 && j == v.force_after && !forced) begin
                force_trig = 1'b1;
                forced     = 1;
            end else if (v.stall && $urandom_range(1, 0) == 0) begin
                sample_valid = 1'b0;
            end else begin
                sample_valid = 1'b1;
                sample_in    = stream[j];
                arm          = v.arm_in_post && (j == trig + 2);
                j++;
            end
            @(negedge clk);
            sample_valid = 1'b0;
            force_trig   = 1'b0;
            arm          = 1'b0;
            sample_in    = 8'($urandom);
            cyc++;
            if (done) begin
                got_done = 1;
                chk({tag, "_done_timing"}, j - 1, last);
            end
        end
        if (!got_done) chk({tag, "_done_timeout"}, 0, 1);
    endtask

    task automatic readout(input string tag, input vec_t v);
        logic [7:0] got [$];
        chk({tag, "_done_before_read"}, done, 1);
        for (int k = 0; k < DEPTH; k++) begin
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            chk({tag, "_rd_valid"}, rd_valid, 1);
            got.push_back(rd_data);
            if (k < exp_q.size()) chk({tag, "_rd_data"}, rd_data, exp_q[k]);
            @(negedge clk);
            chk({tag, "_rd_valid_pulse"}, rd_valid, 0);
            chk({tag, "_rd_data_hold"}, rd_data, got[k]);
        end
        if (v.has_exp) begin
            chk({tag, "_tbl_rd0"}, got[0], v.exp0);
            chk({tag, "_tbl_rd1"}, got[1], v.exp1);
            chk({tag, "_tbl_rd2"}, got[2], v.exp2);
        end
        chk({tag, "_idle_done"}, done, 0);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    task automatic reset_check(input string tag, input int cycles);
        rst_n = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            sample_in = 8'($urandom); sample_valid = 1'($urandom); trig_level = 8'($urandom);
            trig_edge = 1'($urandom); pretrig = 4'($urandom); arm = 1'($urandom);
            force_trig = 1'($urandom); rd_en = 1'($urandom);
            @(negedge clk);
        end
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        rst_n = 1'b1;
        sample_valid = 1'b0; arm = 1'b0; force_trig = 1'b0; rd_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t rv;
        rst_n = 1'b0; sample_in = '0; sample_valid = 1'b0; trig_level = '0; trig_edge = 1'b0;
        pretrig = '0; arm = 1'b0; force_trig = 1'b0; rd_en = 1'b0;

        //          lvl    edge pre  start  step  force stall aip has  exp0   exp1   exp2
        vecs[0] = '{8'h80, 1'b0, 4, 8'h00, 8'h10, -1, 0, 0, 1, 8'h40, 8'h50, 8'h60};
        vecs[1] = '{8'h40, 1'b1, 2, 8'hF0, 8'hE0, -1, 0, 0, 1, 8'h70, 8'h50, 8'h30};
        vecs[2] = '{8'h80, 1'b0, 0, 8'h11, 8'h00,  3, 0, 0, 1, 8'h11, 8'h11, 8'h11};
        vecs[3] = '{8'h30, 1'b0, 8, 8'h00, 8'h10, -1, 0, 1, 1, 8'hB0, 8'hC0, 8'hD0};
        vecs[4] = '{8'h80, 1'b0, 4, 8'h00, 8'h10, -1, 1, 0, 1, 8'h40, 8'h50, 8'h60};
        vecs[5] = '{8'h80, 1'b0, 15, 8'h00, 8'h10, -1, 0, 0, 1, 8'h90, 8'hA0, 8'hB0};

        @(negedge clk);
        reset_check("reset", 2);

        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        chk("rd_en_idle_ignored", rd_valid, 0);

        for (int n = 0; n < 6; n++) begin
            build_ramp(vecs[n]);
            run_capture($sformatf("vec%0d", n), vecs[n]);
            readout($sformatf("vec%0d", n), vecs[n]);
        end

        for (int t = 0; t < 8; t++) begin
            rv = '{8'($urandom_range(223, 32)), 1'($urandom), 4'($urandom), 8'h00, 8'h00,
                   -1, 1'($urandom), 0, 0, 8'h00, 8'h00, 8'h00};
            stream.delete();
            for (int i = 0; i < 300; i++) stream.push_back(8'($urandom));
            run_capture($sformatf("rnd%0d", t), rv);
            if (exp_q.size() == DEPTH) readout($sformatf("rnd%0d", t), rv);
        end

        // Reset in the middle of POST abandons the capture; the next one still works.
        build_ramp(vecs[0]);
        do_arm(vecs[0]);
        for (int j = 0; j < 14; j++) begin
            sample_valid = 1'b1;
            sample_in    = stream[j];
            @(negedge clk);
        end
        sample_valid = 1'b0;
        chk("mid_post_busy", busy, 1);
        reset_check("mid_post_reset", 1);
        run_capture("after_reset", vecs[0]);
        readout("after_reset", vecs[0]);

        // arm together with rd_en in DONE: arm wins, no read.
        run_capture("arm_rd", vecs[0]);
        trig_level = 8'h80; trig_edge = 1'b0; pretrig = 4'd4;
        arm = 1'b1; rd_en = 1'b1;
        @(negedge clk);
        arm = 1'b0; rd_en = 1'b0;
        chk("arm_rd_no_valid", rd_valid, 0);
        chk("arm_rd_busy", busy, 1);
        chk("arm_rd_done", done, 0);
        reset_check("final_reset", 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/scope_trigger_capture.md
SCOPE_TRIGGER_CAPTURE -- requirements
Module: scope_trigger_capture

Interface
REQ-001 SHALL have parameter DATA_W, default 8, sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 64, capture buffer depth in samples; power of two, minimum 4.
REQ-003 SHALL derive ADDR_W = clog2(DEPTH), not user-overridable.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006 sample_in  input  DATA_W  ADC sample, unsigned.
REQ-007 sample_valid  input  1  sample_in qualifies this cycle.
REQ-008 trig_level  input  DATA_W  trigger threshold, unsigned.
REQ-009 trig_edge  input  1  0 = rising, 1 = falling.
REQ-010 pretrig  input  ADDR_W  pre-trigger sample count, 0..DEPTH-1.
REQ-011 arm  input  1  one-cycle pulse, start capture.
REQ-012 force_trig  input  1  one-cycle pulse, trigger without level match.
REQ-013 rd_en  input  1  one-cycle pulse, request next readout sample.
REQ-014 rd_data  output  DATA_W  readout sample.
REQ-015 rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-016 busy  output  1  high in PRETRIG, ARMED, POST.
REQ-017 done  output  1  high in DONE.

Function
REQ-018 SHALL implement states IDLE, PRETRIG, ARMED, POST, DONE.
REQ-019 arm in IDLE or DONE: latch trig_level, trig_edge, pretrig; clear write pointer, sample counter, prev-valid flag, pending-force flag; next state PRETRIG, or ARMED if pretrig = 0. arm in PRETRIG/ARMED/POST SHALL be ignored.
REQ-020 In PRETRIG, ARMED, POST each valid sample SHALL be written at write pointer, pointer incremented mod DEPTH.
REQ-021 PRETRIG SHALL count valid samples; on the write making count = latched pretrig, next state ARMED. Trigger conditions SHALL be ignored in PRETRIG.
REQ-022 prev sample register SHALL update on every valid sample in PRETRIG/ARMED/POST; prev-valid flag set by first such sample.
REQ-023 Rising trigger: valid sample in ARMED, prev-valid = 1, prev < level, sample >= level. Falling: prev > level, sample <= level. Compare unsigned, full DATA_W.
REQ-024 force_trig in ARMED SHALL set pending-force; next valid sample in ARMED SHALL be trigger sample regardless of level. force_trig outside ARMED ignored.
REQ-025 Trigger sample SHALL be written, its address latched as trig_addr, state POST; it counts as first post sample.
REQ-026 POST SHALL capture DEPTH - pretrig samples total including trigger sample; after last write, next state DONE.
REQ-027 In DONE, readout address starts at (trig_addr - pretrig) mod DEPTH; each rd_en SHALL return next sample on rd_data with rd_valid exactly one cycle later, address incrementing mod DEPTH.
REQ-028 After the DEPTH-th rd_valid, state SHALL return to IDLE; rd_en in any state other than DONE ignored, rd_valid stays 0.
REQ-029 rd_en and arm same cycle in DONE: arm wins, no rd_valid produced.
REQ-030 sample_valid low SHALL stall all counters and pointers; no state change from sample-driven conditions.
REQ-031 rd_data SHALL hold last read value when rd_valid is 0.

Reset
REQ-032 rst_n low SHALL force IDLE, clear pointers, counters, flags, latched config; busy = 0, done = 0, rd_valid = 0, rd_data = 0, next cycle.
REQ-033 Reset mid-capture or mid-readout SHALL abandon operation; buffer contents need not be cleared.

Verification (DEPTH = 16, DATA_W = 8)
REQ-034 Reset: rst_n low 2 cycles with random inputs -> busy = done = rd_valid = 0, rd_data = 0x00.
REQ-035 Rising: level 0x80, pretrig 4, arm, ramp 0x00 step 0x10 every cycle -> trigger at 0x80; 16 reads return 0x40..0xF0, 0x00, 0x10, 0x20, 0x30; then IDLE.
REQ-036 Falling: level 0x40, pretrig 2, ramp 0xF0 step -0x20 -> trigger at 0x30; first three reads 0x70, 0x50, 0x30.
REQ-037 Force: pretrig 0, constant 0x11, force_trig after 3 samples -> next sample is trigger; 16 reads all 0x11; done after exactly 16 samples post-trigger.
REQ-038 Ignore: pretrig 8, crossing within first 8 samples -> no trigger until later crossing in ARMED; arm during POST has no effect.
REQ-039 Stall/reset: sample_valid toggled 50% -> same readout as REQ-035; rst_n low mid-POST -> IDLE, busy 0, next arm captures correctly.
